// File: rtl/seg7_reader.sv
// Reads a multiplexed, active-low 7-segment hex display and rebuilds the 4-digit value.
// A digit is captured once after it has been held steady; a full set of four digits commits a frame.
module seg7_reader #(
  parameter int STABLE_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        A,
  input  logic        B,
  input  logic        C,
  input  logic        D,
  input  logic        E,
  input  logic        F,
  input  logic        G,
  input  logic [3:0]  AN,
  output logic [15:0] VALUE,
  output logic        VALID,
  output logic        ERR,
  output logic [3:0]  SEEN
);

  localparam logic [3:0] STABLE = 4'(STABLE_CYC);

  typedef enum logic [1:0] {IDLE, COLLECT, COMMIT} state_t;

  state_t      state_reg, state_next;
  logic [10:0] sample_reg;
  logic [10:0] sample_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [3:0]  seen_reg, seen_next;
  logic [15:0] value_reg, value_next;
  logic        err_reg, err_next;
  logic [3:0]  slot_reg [4];
  logic [3:0]  slot_next [4];

  logic        same;
  logic        an_ok;
  logic [1:0]  digit_idx;
  logic        dec_ok;
  logic [3:0]  nibble;
  logic        capture;
  logic        wr_en;

  assign sample_next = {AN, A, B, C, D, E, F, G};

  // Digit select must be exactly one low bit; anything else is a blanking/transition sample.
  always_comb begin
    an_ok     = 1'b1;
    digit_idx = 2'd0;
    case (sample_reg[10:7])
      4'b1110: digit_idx = 2'd0;
      4'b1101: digit_idx = 2'd1;
      4'b1011: digit_idx = 2'd2;
      4'b0111: digit_idx = 2'd3;
      default: an_ok = 1'b0;
    endcase
  end

  always_comb begin
    dec_ok = 1'b1;
    nibble = 4'h0;
    case (sample_reg[6:0])
      7'h01: nibble = 4'h0;
      7'h4F: nibble = 4'h1;
      7'h12: nibble = 4'h2;
      7'h06: nibble = 4'h3;
      7'h4C: nibble = 4'h4;
      7'h24: nibble = 4'h5;
      7'h20: nibble = 4'h6;
      7'h0F: nibble = 4'h7;
      7'h00: nibble = 4'h8;
      7'h04: nibble = 4'h9;
      7'h08: nibble = 4'hA;
      7'h60: nibble = 4'hB;
      7'h31: nibble = 4'hC;
      7'h42: nibble = 4'hD;
      7'h30: nibble = 4'hE;
      7'h38: nibble = 4'hF;
      default: dec_ok = 1'b0;
    endcase
  end

  // The counter passes STABLE exactly once per steady period because it saturates at 15.
  always_comb begin
    same     = (sample_next == sample_reg);
    cnt_next = 4'd0;
    if (same && an_ok)
      cnt_next = (cnt_reg == 4'hF) ? cnt_reg : cnt_reg + 4'd1;
    capture  = same && an_ok && (cnt_reg == STABLE - 4'd1);
    wr_en    = capture && dec_ok;
    err_next = capture && !dec_ok;
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
      always_comb begin
        slot_next[gi] = slot_reg[gi];
        if (wr_en && digit_idx == 2'(gi))
          slot_next[gi] = nibble;
      end
    end
  endgenerate

  always_comb begin
    seen_next  = seen_reg;
    value_next = value_reg;
    state_next = state_reg;
    if (wr_en)
      seen_next = seen_reg | (4'b0001 << digit_idx);
    if (seen_next == 4'b1111) begin
      value_next = {slot_next[3], slot_next[2], slot_next[1], slot_next[0]};
      seen_next  = 4'b0000;
      state_next = COMMIT;
    end else if (seen_next != 4'b0000) begin
      state_next = COLLECT;
    end else begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      sample_reg <= '1;
      cnt_reg    <= 4'd0;
      seen_reg   <= 4'b0000;
      value_reg  <= 16'h0000;
      err_reg    <= 1'b0;
      for (int i = 0; i < 4; i++)
        slot_reg[i] <= 4'h0;
    end else begin
      state_reg  <= state_next;
      sample_reg <= sample_next;
      cnt_reg    <= cnt_next;
      seen_reg   <= seen_next;
      value_reg  <= value_next;
      err_reg    <= err_next;
      for (int i = 0; i < 4; i++)
        slot_reg[i] <= slot_next[i];
    end
  end

  assign VALUE = value_reg;
  assign VALID = (state_reg == COMMIT);
  assign ERR   = err_reg;
  assign SEEN  = seen_reg;

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader: expected frame/error events are queued as stimulus is
// driven and popped by a monitor whenever VALID or ERR pulses.
module tb_seg7_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        A, B, C, D, E, F, G;
  logic [3:0]  AN;
  logic [15:0] VALUE;
  logic        VALID, ERR;
  logic [3:0]  SEEN;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        is_valid;
    logic [15:0] value;
  } exp_t;

  exp_t        q[$];
  logic [15:0] exp_value = 16'h0000;
  logic [6:0]  seg_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  seg7_reader #(.STABLE_CYC(2)) dut (
    .clk(clk), .rst(rst),
    .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G),
    .AN(AN), .VALUE(VALUE), .VALID(VALID), .ERR(ERR), .SEEN(SEEN)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs, then wait n rising edges and settle 1 time unit past the last one.
  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
    AN = an;
    {A, B, C, D, E, F, G} = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic digit(input int idx, input int nib, input int n);
    logic [3:0] an;
    an = ~(4'b0001 << idx);
    drive(an, seg_tab[nib], n);
  endtask

  task automatic push(input logic is_valid, input logic [15:0] value);
    exp_t e;
    e.is_valid = is_valid;
    e.value    = value;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && (VALID || ERR)) begin
      exp_t e;
      total++;
      assert (!(VALID && ERR)) else begin
        bad++;
        $error("FAIL valid_err_overlap valid=%b err=%b expected one only", VALID, ERR);
      end
      total++;
      assert (q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_event valid=%b err=%b value=%h expected no event", VALID, ERR, VALUE);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        $display("txn valid=%b err=%b value=%h (expected valid=%b value=%h)",
                 VALID, ERR, VALUE, e.is_valid, e.value);
        total++;
        assert (VALID === e.is_valid) else begin
          bad++;
          $error("FAIL event_kind valid=%b expected=%b", VALID, e.is_valid);
        end
        total++;
        assert (VALUE === e.value) else begin
          bad++;
          $error("FAIL event_value observed=%h expected=%h", VALUE, e.value);
        end
      end
    end
  end

  initial begin
    drive(4'b1111, 7'h7F, 0);
    #2;
    check("reset_value", VALUE, 16'h0000);
    check("reset_valid", {15'b0, VALID}, 16'h0);
    check("reset_err", {15'b0, ERR}, 16'h0);
    check("reset_seen", {12'b0, SEEN}, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic frame 0x0123, checking SEEN as it builds up.
    digit(0, 3, 4);
    check("seen_d0", {12'b0, SEEN}, 16'h0001);
    digit(1, 2, 4);
    check("seen_d1", {12'b0, SEEN}, 16'h0003);
    digit(2, 1, 4);
    check("seen_d2", {12'b0, SEEN}, 16'h0007);
    exp_value = 16'h0123;
    push(1'b1, exp_value);
    digit(3, 0, 4);
    check("frame_value", VALUE, 16'h0123);
    check("frame_seen_clear", {12'b0, SEEN}, 16'h0);

    // Undecodable pattern: ERR exactly at the second edge after first sample.
    drive(4'b1111, 7'h7F, 1);
    push(1'b0, exp_value);
    drive(4'b1110, 7'h7F, 2);
    check("err_early", {15'b0, ERR}, 16'h0);
    drive(4'b1110, 7'h7F, 1);
    check("err_pulse", {15'b0, ERR}, 16'h1);
    drive(4'b1110, 7'h7F, 1);
    check("err_end", {15'b0, ERR}, 16'h0);
    check("err_seen", {12'b0, SEEN}, 16'h0);
    check("err_value_hold", VALUE, 16'h0123);

    // Sample changing every cycle never becomes stable.
    for (int i = 0; i < 5; i++) begin
      drive(4'b1110, 7'h06, 1);
      drive(4'b1110, 7'h12, 1);
    end
    check("toggle_seen", {12'b0, SEEN}, 16'h0);

    // Invalid digit enables are ignored.
    drive(4'b1100, 7'h06, 10);
    drive(4'b1111, 7'h01, 10);
    check("bad_an_seen", {12'b0, SEEN}, 16'h0);

    // Reset in the middle of a frame discards partial digits.
    digit(0, 4, 4);
    digit(1, 5, 4);
    digit(2, 6, 4);
    check("pre_rst_seen", {12'b0, SEEN}, 16'h0007);
    rst = 1'b1;
    #1;
    check("async_rst_seen", {12'b0, SEEN}, 16'h0);
    check("async_rst_value", VALUE, 16'h0000);
    exp_value = 16'h0000;
    @(posedge clk);
    #1;
    rst = 1'b0;
    digit(3, 7, 4);
    check("post_rst_seen", {12'b0, SEEN}, 16'h0008);
    check("post_rst_value", VALUE, 16'h0000);

    // Long holds capture once; slot 0 is then overwritten before the frame completes.
    digit(0, 9, 20);
    check("long_hold_seen", {12'b0, SEEN}, 16'h0009);
    push(1'b0, exp_value);
    drive(4'b1101, 7'h7F, 20);
    check("long_err_seen", {12'b0, SEEN}, 16'h0009);
    digit(0, 10, 4);
    digit(1, 1, 4);
    exp_value = 16'h721A;
    push(1'b1, exp_value);
    digit(2, 2, 4);
    check("overwrite_value", VALUE, 16'h721A);

    // Every table entry through slot 0.
    for (int k = 0; k < 16; k++) begin
      logic [3:0] kn;
      kn = 4'(k);
      digit(0, k, 4);
      digit(1, 3, 4);
      digit(2, 12, 4);
      exp_value = {4'hE, 4'hC, 4'h3, kn};
      push(1'b1, exp_value);
      digit(3, 14, 4);
      check("table_nibble", {12'b0, VALUE[3:0]}, {12'b0, kn});
    end

    drive(4'b1111, 7'h7F, 5);
    check("queue_drained", 16'(q.size()), 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
